exc_entry_ctrl: RTL

EXC_ENTRY_CTRL -- requirements
Module: exc_entry_ctrl

---
 rtl/exc_pkg.sv | 33 +++
 rtl/exc_entry_ctrl_if.sv | 43 ++++
 rtl/exc_entry_ctrl_prio_stack.sv | 55 +++++
 rtl/exc_entry_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
`default_nettype none
// ============================================================================
// Package  : exc_pkg
// Desc     : Shared types and constants for the exception entry controller:
//            FSM state encoding, priority-stack entry layout, frame geometry
//            and vector table offset.
// Revision : 1.0 - initial release
// ============================================================================
package exc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACK    = 3'd1,
        ST_PUSH   = 3'd2,
        ST_VECTOR = 3'd3,
        ST_RUN    = 3'd4,
        ST_POP    = 3'd5
    } exc_state_t;

    // Execution priority reported when no handler is active.
    localparam logic [2:0] THREAD_PRIO = 3'd4;
    // Words per stacked frame.
    localparam int FRAME_WORDS = 8;
    // First external interrupt slot in the vector table.
    localparam int VEC_OFFSET = 16;

    typedef struct packed {
        logic [4:0] id;
        logic [1:0] prio;
    } prio_entry_t;

endpackage
`default_nettype wire

// File: rtl/exc_entry_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface: exc_entry_ctrl_if
// Desc     : Bundles the NVIC handshake, core stack-pointer/vector handoff
//            and stack memory port of the exception entry controller.
//            master = controller side, slave = NVIC/core/memory side.
// Revision : 1.0 - initial release
// ============================================================================
interface exc_entry_ctrl_if;
    logic        irq_valid;
    logic [4:0]  irq_id;
    logic [1:0]  irq_prio;
    logic        irq_ack;
    logic [4:0]  irq_ack_id;
    logic [31:0] sp_in;
    logic [31:0] sp_out;
    logic        sp_load;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [2:0]  stack_idx;
    logic        mem_ready;
    logic        exc_return;
    logic [31:0] vec_addr;
    logic        vec_load;
    logic        handler_active;
    logic [2:0]  cur_prio;

    modport master (
        input  irq_valid, irq_id, irq_prio, sp_in, mem_ready, exc_return,
        output irq_ack, irq_ack_id, sp_out, sp_load, mem_req, mem_we,
               mem_addr, stack_idx, vec_addr, vec_load, handler_active,
               cur_prio
    );

    modport slave (
        output irq_valid, irq_id, irq_prio, sp_in, mem_ready, exc_return,
        input  irq_ack, irq_ack_id, sp_out, sp_load, mem_req, mem_we,
               mem_addr, stack_idx, vec_addr, vec_load, handler_active,
               cur_prio
    );
endinterface
`default_nettype wire

// File: rtl/exc_entry_ctrl_prio_stack.sv
`default_nettype none
// ============================================================================
// Module   : prio_stack
// Desc     : LIFO of active handler {id, prio} entries.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            i_push, i_entry - push request and entry to store
//            i_pop           - pop request
//            o_top           - top entry (zero when empty)
//            o_depth         - number of stored entries
//            o_full, o_empty - occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module prio_stack
    import exc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  prio_entry_t                  i_entry,
    input  logic                         i_pop,
    output prio_entry_t                  o_top,
    output logic [$clog2(DEPTH+1)-1:0]   o_depth,
    output logic                         o_full,
    output logic                         o_empty
);
    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_dw = $clog2(DEPTH + 1);

    prio_entry_t     r_stack [DEPTH];
    logic [c_dw-1:0] r_depth;
    logic [c_aw-1:0] w_wr_ptr;
    logic [c_aw-1:0] w_top_ptr;

    assign w_wr_ptr  = c_aw'(r_depth);
    assign w_top_ptr = c_aw'(r_depth - c_dw'(1));
    assign o_full    = (r_depth == c_dw'(DEPTH));
    assign o_empty   = (r_depth == '0);
    assign o_depth   = r_depth;
    assign o_top     = o_empty ? '0 : r_stack[w_top_ptr];

    // Entry storage is not reset: only slots below r_depth are ever read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_depth <= '0;
        end else if (i_push && !o_full) begin
            r_stack[w_wr_ptr] <= i_entry;
            r_depth           <= r_depth + c_dw'(1);
        end else if (i_pop && !o_empty) begin
            r_depth <= r_depth - c_dw'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/exc_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exc_entry_ctrl
// Desc     : Exception entry/exit sequencer. Accepts a preempting interrupt,
//            acknowledges it, stacks an 8-word frame below the current SP,
//            hands the core the new SP and vector address, and unstacks the
//            frame again on exception return. Supports NEST_DEPTH nesting.
// Ports    : clk  - system clock (rising edge)
//            rst  - synchronous active-high reset
//            bus  - exc_entry_ctrl_if.master (NVIC, core SP/PC, stack memory)
// Revision : 1.0 - initial release
// ============================================================================
module exc_entry_ctrl
    import exc_pkg::*;
#(
    parameter int          NEST_DEPTH = 4,
    parameter logic [31:0] VTOR       = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    exc_entry_ctrl_if.master  bus
);
    localparam int          c_dw          = $clog2(NEST_DEPTH + 1);
    localparam logic [31:0] c_frame_bytes = 32'(FRAME_WORDS * 4);
    localparam logic [2:0]  c_last_idx    = 3'(FRAME_WORDS - 1);

    exc_state_t      r_state, w_state_nxt;
    logic [31:0]     r_base, w_base_nxt;
    logic [2:0]      r_idx, w_idx_nxt;
    prio_entry_t     r_req, w_req_nxt;
    logic            w_push, w_pop, w_full, w_empty, w_accept;
    prio_entry_t     w_top;
    logic [c_dw-1:0] w_depth;
    logic [2:0]      w_cur_prio;

    prio_stack #(.DEPTH(NEST_DEPTH)) u_prio_stack (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_entry (r_req),
        .i_pop   (w_pop),
        .o_top   (w_top),
        .o_depth (w_depth),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_cur_prio          = w_empty ? THREAD_PRIO : {1'b0, w_top.prio};
    assign bus.cur_prio        = w_cur_prio;
    assign bus.handler_active  = !w_empty;

    // exc_return wins over a simultaneous accept while in RUN.
    assign w_accept = bus.irq_valid && ({1'b0, bus.irq_prio} < w_cur_prio) && !w_full &&
                      ((r_state == ST_IDLE) || ((r_state == ST_RUN) && !bus.exc_return));

    always_comb begin
        w_state_nxt    = r_state;
        w_base_nxt     = r_base;
        w_idx_nxt      = r_idx;
        w_req_nxt      = r_req;
        w_push         = 1'b0;
        w_pop          = 1'b0;
        bus.irq_ack    = 1'b0;
        bus.irq_ack_id = '0;
        bus.sp_load    = 1'b0;
        bus.sp_out     = '0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.stack_idx  = '0;
        bus.vec_load   = 1'b0;
        bus.vec_addr   = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    // Latch the accepted request so ACK reports what was judged.
                    w_req_nxt   = '{id: bus.irq_id, prio: bus.irq_prio};
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                bus.irq_ack    = 1'b1;
                bus.irq_ack_id = r_req.id;
                w_base_nxt     = bus.sp_in - c_frame_bytes;
                w_push         = 1'b1;
                w_idx_nxt      = '0;
                w_state_nxt    = ST_PUSH;
            end
            ST_PUSH: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = r_base + {27'd0, r_idx, 2'b00};
                bus.stack_idx = r_idx;
                if (bus.mem_ready) begin
                    if (r_idx == c_last_idx) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_VECTOR;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
            ST_VECTOR: begin
                // The entry pushed in ACK is now the top of the stack.
                bus.sp_load  = 1'b1;
                bus.sp_out   = r_base;
                bus.vec_load = 1'b1;
                bus.vec_addr = VTOR + {23'd0, 7'(VEC_OFFSET) + {2'b00, w_top.id}, 2'b00};
                w_state_nxt  = ST_RUN;
            end
            ST_RUN: begin
                if (bus.exc_return) begin
                    w_base_nxt  = bus.sp_in;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_POP;
                end else if (w_accept) begin
                    w_req_nxt   = '{id: bus.irq_id, prio: bus.irq_prio};
                    w_state_nxt = ST_ACK;
                end
            end
            ST_POP: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b0;
                bus.mem_addr  = r_base + {27'd0, r_idx, 2'b00};
                bus.stack_idx = r_idx;
                if (bus.mem_ready) begin
                    if (r_idx == c_last_idx) begin
                        bus.sp_load = 1'b1;
                        bus.sp_out  = r_base + c_frame_bytes;
                        w_pop       = 1'b1;
                        w_idx_nxt   = '0;
                        // Depth still includes the frame being popped this cycle.
                        w_state_nxt = (w_depth > c_dw'(1)) ? ST_RUN : ST_IDLE;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_base  <= '0;
            r_idx   <= '0;
            r_req   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_base  <= w_base_nxt;
            r_idx   <= w_idx_nxt;
            r_req   <= w_req_nxt;
        end
    end
endmodule
`default_nettype wire
